// File: rtl/div_alu_pkg.sv
// Shared encodings for the Tomasulo functional units: FSM states and divide opcodes.
package div_alu_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned LastIter  = 31;

  // State encodings shared with the multiply unit.
  typedef enum logic [2:0] {
    sIdle = 3'd0,
    sCalc = 3'd1,
    sFix  = 3'd2,
    sDone = 3'd3
  } state_t;

  // op[1] selects signed, op[0] selects remainder.
  typedef enum logic [1:0] {
    opDivu = 2'b00,
    opRemu = 2'b01,
    opDiv  = 2'b10,
    opRem  = 2'b11
  } op_t;

endpackage

// File: rtl/div_alu_if.sv
// Issue / CDB handshake bundle between reservation station, CDB arbiter and divide unit.
interface div_alu_if;

  logic        WEN;
  logic [1:0]  op;
  logic [31:0] dataIn1;
  logic [31:0] dataIn2;
  logic        available;
  logic        require;
  logic        requireAC;
  logic [31:0] result;
  logic [2:0]  stateOut;

  modport master (
    output WEN, op, dataIn1, dataIn2, requireAC,
    input  available, require, result, stateOut
  );

  modport slave (
    input  WEN, op, dataIn1, dataIn2, requireAC,
    output available, require, result, stateOut
  );

endinterface

// File: rtl/div_step.sv
// One restoring-divide iteration: shift {rem, quo} left, trial-subtract divisor.
module div_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [33:0] shifted;
  logic [33:0] diff;

  // Trial subtraction; diff[33] set means the shifted remainder was smaller than the divisor.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {2'b00, divisor};
    if (!diff[33]) begin
      rem_next = diff[32:0];
      quo_next = {quo[30:0], 1'b1};
    end else begin
      rem_next = shifted[32:0];
      quo_next = {quo[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_alu.sv
// Iterative 32-bit divide/remainder unit: fixed 33-cycle latency, holds result until CDB grant.
module div_alu
  import div_alu_pkg::*;
(
  input logic      clk,
  input logic      nRST,
  div_alu_if.slave bus
);

  state_t      state_q;
  logic [1:0]  op_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] raw1_q;
  logic [31:0] raw2_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;
  logic        require_q;

  logic        available;
  logic        issue;
  logic        is_signed;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] fix_val;

  // Accept when empty, or when the held result is being granted this cycle.
  always_comb begin
    available = (state_q == sIdle) || (require_q && bus.requireAC);
    issue     = bus.WEN && available;
    is_signed = bus.op[1];
    abs1      = (is_signed && bus.dataIn1[31]) ? -bus.dataIn1 : bus.dataIn1;
    abs2      = (is_signed && bus.dataIn2[31]) ? -bus.dataIn2 : bus.dataIn2;
  end

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign fix-up of the magnitude result, then RISC-V special-case overrides.
  always_comb begin
    if (op_q[0]) begin
      fix_val = rneg_q ? -rem_q[31:0] : rem_q[31:0];
    end else begin
      fix_val = qneg_q ? -quo_q : quo_q;
    end
    if (raw2_q == 32'd0) begin
      fix_val = op_q[0] ? raw1_q : 32'hFFFF_FFFF;
    end else if (op_q[1] && raw1_q == 32'h8000_0000 && raw2_q == 32'hFFFF_FFFF) begin
      fix_val = op_q[0] ? 32'd0 : 32'h8000_0000;
    end
  end

  // FSM, operand latches, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= sIdle;
      op_q      <= 2'b00;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      raw1_q    <= '0;
      raw2_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      require_q <= 1'b0;
    end else if (issue) begin
      state_q   <= sCalc;
      op_q      <= bus.op;
      rem_q     <= '0;
      quo_q     <= abs1;
      dvs_q     <= abs2;
      raw1_q    <= bus.dataIn1;
      raw2_q    <= bus.dataIn2;
      qneg_q    <= is_signed && (bus.dataIn1[31] ^ bus.dataIn2[31]);
      rneg_q    <= is_signed && bus.dataIn1[31];
      cnt_q     <= '0;
      require_q <= 1'b0;
    end else begin
      unique case (state_q)
        sCalc: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(LastIter)) state_q <= sFix;
        end
        sFix: begin
          result_q  <= fix_val;
          require_q <= 1'b1;
          state_q   <= sDone;
        end
        sDone: begin
          if (bus.requireAC) begin
            require_q <= 1'b0;
            state_q   <= sIdle;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.available = available;
  assign bus.require   = require_q;
  assign bus.result    = result_q;
  assign bus.stateOut  = state_q;

endmodule

// File: tb/tb_div_alu.sv
// Scoreboard bench for div_alu: driver pushes expected results, monitor checks on require.
module tb_div_alu;
  import div_alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic nRST;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e_m;
  logic seen = 1'b0;
  logic [31:0] held;

  div_alu_if bus ();

  div_alu dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one op once the unit is available; stimulus changes 1 time unit after posedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int n = 0;
    while (!bus.available && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("issue_timeout", 32'd0, 32'd1);
    bus.op      = op;
    bus.dataIn1 = a;
    bus.dataIn2 = b;
    bus.WEN     = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{exp, cyc});
    bus.WEN = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || bus.require) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: first cycle of require pops and checks value/latency; later cycles check hold.
  always @(negedge clk) begin
    if (nRST) begin
      if (bus.require) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e_m = sb.pop_front();
            check("result", bus.result, e_m.res);
            check("latency", 32'(cyc - e_m.t0), 32'd33);
          end
          seen = 1'b1;
          held = bus.result;
        end else begin
          check("hold_result", bus.result, held);
        end
        check("state_done", 32'(bus.stateOut), 32'(sDone));
        check("available_in_done", 32'(bus.available), 32'(bus.requireAC));
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    nRST          = 1'b0;
    bus.WEN       = 1'b0;
    bus.op        = 2'b00;
    bus.dataIn1   = '0;
    bus.dataIn2   = '0;
    bus.requireAC = 1'b1;
    #12;
    check("rst_state", 32'(bus.stateOut), 32'(sIdle));
    check("rst_result", bus.result, 32'd0);
    check("rst_require", 32'(bus.require), 32'd0);
    check("rst_available", 32'(bus.available), 32'd1);
    @(posedge clk);
    #3;
    nRST = 1'b1;
    @(posedge clk);
    #1;

    // Basic and signed/special-case vectors, grant tied high, back-to-back issue.
    issue(opDivu, 32'd100, 32'd7, 32'd14);
    issue(opRem,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    issue(opDiv,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    issue(opDiv,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    issue(opRem,  32'd100, 32'hFFFF_FFF9, 32'd2);
    issue(opDivu, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue(opRemu, 32'd5, 32'd0, 32'd5);
    issue(opDiv,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    issue(opRem,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    issue(opDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(opRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue(opDivu, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999);
    issue(opRemu, 32'hFFFF_FFFF, 32'd10, 32'd5);
    wait_drain();

    // CDB stall: WEN during stall must be ignored; then grant together with a new issue.
    bus.requireAC = 1'b0;
    issue(opDivu, 32'd50, 32'd5, 32'd10);
    for (int i = 0; i < 60 && !bus.require; i++) begin
      @(posedge clk);
      #1;
    end
    check("stall_require", 32'(bus.require), 32'd1);
    bus.op      = opDivu;
    bus.dataIn1 = 32'd1;
    bus.dataIn2 = 32'd1;
    bus.WEN     = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("stall_state", 32'(bus.stateOut), 32'(sDone));
    bus.dataIn1   = 32'd9;
    bus.dataIn2   = 32'd3;
    bus.requireAC = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{32'd3, cyc});
    bus.WEN = 1'b0;
    check("grant_issue_state", 32'(bus.stateOut), 32'(sCalc));
    check("grant_require_low", 32'(bus.require), 32'd0);
    wait_drain();

    // Asynchronous reset mid-calculation aborts the op.
    issue(opDivu, 32'd1000, 32'd10, 32'd100);
    repeat (10) @(posedge clk);
    #2;
    nRST = 1'b0;
    #1;
    check("abort_state", 32'(bus.stateOut), 32'(sIdle));
    check("abort_result", bus.result, 32'd0);
    check("abort_require", 32'(bus.require), 32'd0);
    void'(sb.pop_back());
    @(posedge clk);
    #3;
    nRST = 1'b1;
    @(posedge clk);
    #1;
    issue(opRemu, 32'd1000, 32'd7, 32'd6);
    wait_drain();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
